// File: rtl/toy_mem_arbiter_if.sv
// Purpose: bundles the icache port, data port and external memory bus seen by toy_mem_arbiter.
// Ports:   icache read (ic_*), data load/store (dc_*), external memory (mem_*).
// Modports: slave = the arbiter itself, master = the requesters plus memory around it.
interface toy_mem_arbiter_if;
  // icache line-fill read port
  logic        ic_rd;
  logic [31:0] ic_address;
  logic [31:0] ic_data_in;
  logic        ic_data_in_ready;
  // data-side load/store port
  logic        dc_rd;
  logic        dc_wr;
  logic [31:0] dc_address;
  logic [31:0] dc_data_out;
  logic [31:0] dc_data_in;
  logic        dc_data_in_ready;
  // external memory bus
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  ic_rd, ic_address, dc_rd, dc_wr, dc_address, dc_data_out, mem_rdata, mem_ready,
    output ic_data_in, ic_data_in_ready, dc_data_in, dc_data_in_ready,
           mem_rd, mem_wr, mem_address, mem_wdata
  );

  modport master (
    output ic_rd, ic_address, dc_rd, dc_wr, dc_address, dc_data_out, mem_rdata, mem_ready,
    input  ic_data_in, ic_data_in_ready, dc_data_in, dc_data_in_ready,
           mem_rd, mem_wr, mem_address, mem_wdata
  );
endinterface

// File: rtl/toy_mem_arbiter.sv
// Purpose: merges icache reads and data-port loads/stores onto one memory bus, one transaction at a time.
// Latency: grant edge -> strobe 1 edge; mem_ready edge -> port ready pulse 1 edge; one release cycle after each.
// Backpressure: requests are levels held until the one-cycle ready pulse; mem_ready is the only bus stall.
// Ports: clk, reset (async active-low); bus (slave modport) carries ic_*, dc_* and mem_* signals.
module toy_mem_arbiter #(
  parameter int unsigned IC_BURST_MAX = 4
) (
  input logic              clk,
  input logic              reset,
  toy_mem_arbiter_if.slave bus
);

  localparam int unsigned SW = (IC_BURST_MAX < 1) ? 1 : $clog2(IC_BURST_MAX + 1);
  localparam logic [SW-1:0] BURST_MAX = SW'(IC_BURST_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IC_BUSY = 2'd1,
    S_DC_BUSY = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] ic_streak_q, ic_streak_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [31:0]   mem_address_q, mem_address_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   ic_data_q, ic_data_d;
  logic [31:0]   dc_data_q, dc_data_d;
  logic          ic_ready_q, ic_ready_d;
  logic          dc_ready_q, dc_ready_d;
  logic          ic_req, dc_req, ic_wins;

  always_comb begin
    state_d       = state_q;
    ic_streak_d   = ic_streak_q;
    mem_rd_d      = mem_rd_q;
    mem_wr_d      = mem_wr_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    ic_data_d     = ic_data_q;
    dc_data_d     = dc_data_q;
    ic_ready_d    = 1'b0;
    dc_ready_d    = 1'b0;
    ic_req        = bus.ic_rd;
    dc_req        = bus.dc_rd | bus.dc_wr;
    // The streak only grows while below the cap, so "not yet at cap" is
    // the same as "below cap"; with a cap of 0 the data port always wins.
    ic_wins       = ic_req && (!dc_req || (ic_streak_q != BURST_MAX));

    case (state_q)
      S_IDLE: begin
        if (ic_wins) begin
          state_d       = S_IC_BUSY;
          mem_rd_d      = 1'b1;
          mem_wr_d      = 1'b0;
          mem_address_d = bus.ic_address;
          mem_wdata_d   = '0;
          // Only a grant taken over a waiting data request counts toward the streak.
          if (dc_req) ic_streak_d = ic_streak_q + SW'(1);
        end else if (dc_req) begin
          state_d       = S_DC_BUSY;
          mem_rd_d      = !bus.dc_wr;
          mem_wr_d      = bus.dc_wr;
          mem_address_d = bus.dc_address;
          mem_wdata_d   = bus.dc_wr ? bus.dc_data_out : 32'd0;
          ic_streak_d   = '0;
        end
      end
      S_IC_BUSY, S_DC_BUSY: begin
        if (bus.mem_ready) begin
          state_d  = S_RELEASE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          // Writes also hand mem_rdata back; the data port ignores it.
          if (state_q == S_IC_BUSY) begin
            ic_data_d  = bus.mem_rdata;
            ic_ready_d = 1'b1;
          end else begin
            dc_data_d  = bus.mem_rdata;
            dc_ready_d = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        // Gives the requester the ready cycle to drop its request before re-arbitration.
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ic_streak_q   <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      ic_data_q     <= '0;
      dc_data_q     <= '0;
      ic_ready_q    <= 1'b0;
      dc_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ic_streak_q   <= ic_streak_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      ic_data_q     <= ic_data_d;
      dc_data_q     <= dc_data_d;
      ic_ready_q    <= ic_ready_d;
      dc_ready_q    <= dc_ready_d;
    end
  end

  assign bus.mem_rd           = mem_rd_q;
  assign bus.mem_wr           = mem_wr_q;
  assign bus.mem_address      = mem_address_q;
  assign bus.mem_wdata        = mem_wdata_q;
  assign bus.ic_data_in       = ic_data_q;
  assign bus.ic_data_in_ready = ic_ready_q;
  assign bus.dc_data_in       = dc_data_q;
  assign bus.dc_data_in_ready = dc_ready_q;

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// Purpose: scoreboard bench for toy_mem_arbiter with a reference arbitration model.
// Latency: driver queues expected grants and data; the memory responder and monitor check them.
// Backpressure: memory latency randomised 0..3 cycles; requests held until ready or dropped early.
module tb_toy_mem_arbiter;

  localparam int BURST = 4;

  typedef struct {
    bit          is_ic;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
  } bus_item_t;

  logic clk = 1'b0;
  logic reset;

  toy_mem_arbiter_if bus0();
  toy_mem_arbiter_if bus1();

  toy_mem_arbiter #(.IC_BURST_MAX(BURST)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  toy_mem_arbiter #(.IC_BURST_MAX(0))     dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  always #5 clk = ~clk;

  bus_item_t   bus_q[$];
  bus_item_t   mem_q[$];
  logic [31:0] ic_exp_q[$];
  logic [31:0] dc_exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_streak = 0;
  bit          mon_en   = 1'b0;
  bit          resp_en  = 1'b0;
  bit          force_rdata = 1'b0;
  logic [31:0] forced_rdata = '0;

  // Memory side of bus0: responder when enabled, otherwise directly driven values.
  logic        resp_rdy = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        dir_rdy = 1'b0;
  logic [31:0] dir_rdata = '0;
  assign bus0.mem_ready = resp_rdy | dir_rdy;
  assign bus0.mem_rdata = resp_en ? resp_rdata : dir_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: ic wins unless dc is waiting and ic already had BURST grants in a row over it.
  function automatic bit model_grant_ic(input bit icp, input bit dcp);
    bit win;
    win = icp && (!dcp || (m_streak < BURST));
    if (win && dcp) m_streak = (m_streak < BURST) ? m_streak + 1 : BURST;
    else if (!win) m_streak = 0;
    return win;
  endfunction

  task automatic push_item(input bus_item_t it);
    bus_q.push_back(it);
    mem_q.push_back(it);
  endtask

  // Memory responder for bus0
  bus_item_t r_cur;
  bit        r_busy = 1'b0;
  bit        r_prev = 1'b0;
  logic      r_strobe;
  int        r_cnt = 0;
  always @(negedge clk) begin
    if (resp_en) begin
      resp_rdy = 1'b0;
      r_strobe = bus0.mem_rd | bus0.mem_wr;
      if (!r_busy && r_strobe && !r_prev && mem_q.size() > 0) begin
        r_cur  = mem_q.pop_front();
        r_busy = 1'b1;
        r_cnt  = r_cur.lat;
      end else if (r_busy && r_cnt > 0) begin
        r_cnt--;
      end
      if (r_busy && r_cnt == 0) begin
        resp_rdata = force_rdata ? forced_rdata : $urandom;
        resp_rdy   = 1'b1;
        if (r_cur.is_ic) ic_exp_q.push_back(resp_rdata);
        else             dc_exp_q.push_back(resp_rdata);
        r_busy = 1'b0;
      end
      r_prev = r_strobe;
    end else begin
      resp_rdy = 1'b0;
      r_busy   = 1'b0;
      r_prev   = 1'b0;
    end
  end

  // Monitor for bus0
  bus_item_t m_cur;
  bit        m_prev = 1'b0;
  bit        m_act  = 1'b0;
  logic      m_strobe;
  always @(negedge clk) begin
    if (mon_en) begin
      m_strobe = bus0.mem_rd | bus0.mem_wr;
      if (m_strobe && !m_prev) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_grant", 32'(m_strobe), 32'd0);
        end else begin
          m_cur = bus_q.pop_front();
          m_act = 1'b1;
          chk("grant_mem_rd", 32'(bus0.mem_rd), 32'(!m_cur.wr));
          chk("grant_mem_wr", 32'(bus0.mem_wr), 32'(m_cur.wr));
          chk("grant_addr", bus0.mem_address, m_cur.addr);
          chk("grant_wdata", bus0.mem_wdata, m_cur.wdata);
        end
      end else if (m_strobe && m_act) begin
        chk("addr_held", bus0.mem_address, m_cur.addr);
      end
      if (!m_strobe) m_act = 1'b0;
      if (bus0.ic_data_in_ready) begin
        if (ic_exp_q.size() == 0) chk("unexpected_ic_ready", 32'(bus0.ic_data_in_ready), 32'd0);
        else                      chk("ic_data_in", bus0.ic_data_in, ic_exp_q.pop_front());
      end
      if (bus0.dc_data_in_ready) begin
        if (dc_exp_q.size() == 0) chk("unexpected_dc_ready", 32'(bus0.dc_data_in_ready), 32'd0);
        else                      chk("dc_data_in", bus0.dc_data_in, dc_exp_q.pop_front());
      end
      m_prev = m_strobe;
    end else begin
      m_prev = 1'b0;
      m_act  = 1'b0;
    end
  end

  task automatic clear_inputs();
    bus0.ic_rd = 0; bus0.ic_address = '0; bus0.dc_rd = 0; bus0.dc_wr = 0;
    bus0.dc_address = '0; bus0.dc_data_out = '0;
    bus1.ic_rd = 0; bus1.ic_address = '0; bus1.dc_rd = 0; bus1.dc_wr = 0;
    bus1.dc_address = '0; bus1.dc_data_out = '0; bus1.mem_ready = 0; bus1.mem_rdata = '0;
    dir_rdy = 1'b0;
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    resp_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    bus_q.delete(); mem_q.delete(); ic_exp_q.delete(); dc_exp_q.delete();
    m_streak = 0;
    force_rdata = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    mon_en  = 1'b1;
    resp_en = 1'b1;
  endtask

  task automatic run_txn(input bit icp, input bit dcp, input bit dwr, input logic [31:0] ia,
                         input logic [31:0] da, input logic [31:0] dd, input int lat, input bit early);
    bus_item_t it_ic, it_dc;
    int need, got;
    bit seen;
    it_ic.is_ic = 1'b1; it_ic.wr = 1'b0; it_ic.addr = ia; it_ic.wdata = '0; it_ic.lat = lat;
    it_dc.is_ic = 1'b0; it_dc.wr = dwr;  it_dc.addr = da; it_dc.wdata = dwr ? dd : 32'd0; it_dc.lat = lat;
    @(negedge clk);
    bus0.ic_rd = icp; bus0.ic_address = ia;
    bus0.dc_wr = dcp && dwr;
    bus0.dc_rd = dcp && (!dwr || ($urandom_range(0, 1) == 1));
    bus0.dc_address = da; bus0.dc_data_out = dd;
    if (icp && dcp) begin
      need = 2;
      if (model_grant_ic(1'b1, 1'b1)) begin
        push_item(it_ic); void'(model_grant_ic(1'b0, 1'b1)); push_item(it_dc);
      end else begin
        push_item(it_dc); void'(model_grant_ic(1'b1, 1'b0)); push_item(it_ic);
      end
    end else begin
      need = 1;
      void'(model_grant_ic(icp, dcp));
      push_item(icp ? it_ic : it_dc);
    end
    got = 0;
    seen = 1'b0;
    for (int c = 0; c < 100 && got < need; c++) begin
      @(negedge clk);
      if (bus0.ic_data_in_ready) begin bus0.ic_rd = 1'b0; got++; end
      if (bus0.dc_data_in_ready) begin bus0.dc_rd = 1'b0; bus0.dc_wr = 1'b0; got++; end
      if (need == 1 && !seen && (bus0.mem_rd | bus0.mem_wr)) begin
        seen = 1'b1;
        // Scramble the winner's inputs: the bus must keep the values latched at grant.
        if (icp) begin
          bus0.ic_address = $urandom;
          if (early) bus0.ic_rd = 1'b0;
        end else begin
          bus0.dc_address = $urandom; bus0.dc_data_out = $urandom;
          if (early) begin bus0.dc_rd = 1'b0; bus0.dc_wr = 1'b0; end
        end
      end
    end
    chk("txn_ready_count", 32'(got), 32'(need));
  endtask

  task automatic run_contention(input int n);
    bus_item_t it_ic, it_dc;
    int got;
    it_ic.is_ic = 1'b1; it_ic.wr = 1'b0; it_ic.addr = 32'h0000_0A00; it_ic.wdata = '0; it_ic.lat = 0;
    it_dc.is_ic = 1'b0; it_dc.wr = 1'b0; it_dc.addr = 32'h0000_0D00; it_dc.wdata = '0; it_dc.lat = 0;
    @(negedge clk);
    bus0.ic_rd = 1'b1; bus0.ic_address = it_ic.addr;
    bus0.dc_rd = 1'b1; bus0.dc_wr = 1'b0; bus0.dc_address = it_dc.addr;
    for (int i = 0; i < n; i++) push_item(model_grant_ic(1'b1, 1'b1) ? it_ic : it_dc);
    got = 0;
    for (int c = 0; c < 400 && got < n; c++) begin
      @(negedge clk);
      if (bus0.ic_data_in_ready) got++;
      if (bus0.dc_data_in_ready) got++;
      if (got >= n) begin bus0.ic_rd = 1'b0; bus0.dc_rd = 1'b0; end
    end
    chk("contention_ready_count", 32'(got), 32'(n));
  endtask

  logic [31:0] snap_ic, snap_dc, d;
  bit          seen1, saw_rdy;

  initial begin
    reset = 1'b0;
    clear_inputs();
    // Held in reset with every request and mem_ready active: outputs stay at zero.
    bus0.ic_rd = 1'b1; bus0.ic_address = 32'h44;
    bus0.dc_wr = 1'b1; bus0.dc_address = 32'h88; bus0.dc_data_out = 32'h55;
    dir_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_rd", 32'(bus0.mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(bus0.mem_wr), 32'd0);
    chk("rst_mem_address", bus0.mem_address, 32'd0);
    chk("rst_mem_wdata", bus0.mem_wdata, 32'd0);
    chk("rst_ic_data", bus0.ic_data_in, 32'd0);
    chk("rst_dc_data", bus0.dc_data_in, 32'd0);
    chk("rst_ic_ready", 32'(bus0.ic_data_in_ready), 32'd0);
    chk("rst_dc_ready", 32'(bus0.dc_data_in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("first_grant_rd", 32'(bus0.mem_rd), 32'd1);
    chk("first_grant_addr", bus0.mem_address, 32'h44);
    do_reset();

    // icache read, slow memory, fixed data
    force_rdata = 1'b1; forced_rdata = 32'hCAFEF00D;
    run_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 3, 1'b0);
    force_rdata = 1'b0;
    chk("ic_data_hold", bus0.ic_data_in, 32'hCAFEF00D);
    // data-port write
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h2000, 32'h12345678, 1, 1'b0);

    // Stray mem_ready while idle changes nothing.
    resp_en = 1'b0;
    @(negedge clk);
    snap_ic = bus0.ic_data_in; snap_dc = bus0.dc_data_in;
    dir_rdata = $urandom; dir_rdy = 1'b1;
    @(negedge clk);
    dir_rdy = 1'b0;
    @(negedge clk);
    chk("stray_ic_data", bus0.ic_data_in, snap_ic);
    chk("stray_dc_data", bus0.dc_data_in, snap_dc);
    chk("stray_strobes", {30'd0, bus0.mem_rd, bus0.mem_wr}, 32'd0);
    chk("stray_readies", {30'd0, bus0.ic_data_in_ready, bus0.dc_data_in_ready}, 32'd0);
    resp_en = 1'b1;

    // Random mix of single and contending requests.
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      run_txn(kind == 0 || kind == 3, kind != 0, $urandom_range(0, 1) == 1,
              $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Continuous contention from reset: streak cap of 4 interleaves the data port.
    do_reset();
    run_contention(10);
    repeat (4) @(negedge clk);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("ic_exp_empty", 32'(ic_exp_q.size()), 32'd0);
    chk("dc_exp_empty", 32'(dc_exp_q.size()), 32'd0);

    // Reset between edges during an icache transaction.
    do_reset();
    mon_en = 1'b0; resp_en = 1'b0;
    bus0.ic_rd = 1'b1; bus0.ic_address = 32'h700;
    @(posedge clk); #1;
    chk("busy_before_rst", 32'(bus0.mem_rd), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("rst_drops_mem_rd", 32'(bus0.mem_rd), 32'd0);
    bus0.ic_rd = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); dir_rdata = 32'hDEADBEEF; dir_rdy = 1'b1;
    @(negedge clk); dir_rdy = 1'b0;
    saw_rdy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_rdy = saw_rdy | bus0.ic_data_in_ready | bus0.mem_rd;
    end
    chk("rst_no_ready", 32'(saw_rdy), 32'd0);

    // Cap of zero: the data port wins every contended grant.
    do_reset();
    bus1.ic_rd = 1'b1; bus1.ic_address = 32'h300;
    bus1.dc_rd = 1'b1; bus1.dc_address = 32'h400;
    for (int g = 0; g < 4; g++) begin
      seen1 = 1'b0;
      for (int c = 0; c < 20 && !seen1; c++) begin
        @(negedge clk);
        seen1 = bus1.mem_rd | bus1.mem_wr;
      end
      chk("strict_grant_seen", 32'(seen1), 32'd1);
      chk("strict_addr", bus1.mem_address, 32'h400);
      d = $urandom;
      bus1.mem_rdata = d; bus1.mem_ready = 1'b1;
      @(negedge clk);
      bus1.mem_ready = 1'b0;
      chk("strict_dc_ready", 32'(bus1.dc_data_in_ready), 32'd1);
      chk("strict_dc_data", bus1.dc_data_in, d);
      chk("strict_ic_ready", 32'(bus1.ic_data_in_ready), 32'd0);
    end
    bus1.ic_rd = 1'b0; bus1.dc_rd = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
